// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, port indices and the XY routing function.
// Used by the input port and the switch allocator.
package noc_pkg;

   localparam int FLIT_W    = 16;
   localparam int DEST_X_HI = 15;
   localparam int DEST_X_LO = 12;
   localparam int DEST_Y_HI = 11;
   localparam int DEST_Y_LO = 8;
   localparam int NUM_PORTS = 5;

   typedef enum logic [2:0] {
      PORT_N = 3'd0,
      PORT_S = 3'd1,
      PORT_E = 3'd2,
      PORT_W = 3'd3,
      PORT_L = 3'd4
   } port_e;

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   function automatic logic [NUM_PORTS-1:0] xy_route(
      input logic [3:0] dest_x,
      input logic [3:0] dest_y,
      input logic [3:0] cur_x,
      input logic [3:0] cur_y
   );
      logic [NUM_PORTS-1:0] r;
      r = '0;
      if (dest_x > cur_x)
         r[PORT_E] = 1'b1;
      else if (dest_x < cur_x)
         r[PORT_W] = 1'b1;
      else if (dest_y > cur_y)
         r[PORT_N] = 1'b1;
      else if (dest_y < cur_y)
         r[PORT_S] = 1'b1;
      else
         r[PORT_L] = 1'b1;
      return r;
   endfunction

endpackage : noc_pkg

// File: rtl/noc_fifo.sv
// Synchronous FIFO with a separate occupancy counter; read data is forced to
// zero while empty so downstream never sees stale storage.
module noc_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         data,
   output logic [WIDTH-1:0]         q,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the pre-edge count, so a pop never frees room for a
   // push in the same cycle, and a push into an empty FIFO is never popped.
   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; q is masked while empty, so a
   // reset only has to clear pointers and count, keeping the array as plain RAM.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data;
   end

   assign q     = empty ? '0 : mem[rd_ptr];
   assign count = cnt;

endmodule : noc_fifo

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO plus XY route decode of the head flit.
// Optional saturating drop counter enabled by NOC_INPUT_DROP_CNT_EN.
module noc_input_port
   import noc_pkg::*;
#(
   parameter int         DEPTH    = 4,
   parameter logic [3:0] ROUTER_X = 4'd0,
   parameter logic [3:0] ROUTER_Y = 4'd0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [FLIT_W-1:0]       data_i,
   input  logic                    valid_i,
   output logic                    full_o,
   output logic [FLIT_W-1:0]       q_o,
   output logic                    pop_req_o,
   output logic [NUM_PORTS-1:0]    route_o,
   input  logic                    grant_i,
   output logic [$clog2(DEPTH):0]  count_o
`ifdef NOC_INPUT_DROP_CNT_EN
   ,
   output logic [7:0]              drop_cnt_o
`endif
);

   logic [FLIT_W-1:0] head;
   logic              full;
   logic              empty;

   noc_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (valid_i),
      .pop   (grant_i),
      .data  (data_i),
      .q     (head),
      .full  (full),
      .empty (empty),
      .count (count_o)
   );

   assign q_o       = head;
   assign full_o    = full;
   assign pop_req_o = !empty;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      route_o = '0;
      if (!empty)
         route_o = xy_route(head[DEST_X_HI:DEST_X_LO], head[DEST_Y_HI:DEST_Y_LO],
                            ROUTER_X, ROUTER_Y);
   end

`ifdef NOC_INPUT_DROP_CNT_EN
   logic [7:0] drop_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (valid_i && full && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end

   assign drop_cnt_o = drop_cnt;
`endif

endmodule : noc_input_port

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port (ROUTER_X=1, ROUTER_Y=1, DEPTH=4):
// directed scenarios followed by random traffic, all against a queue model.
module tb_noc_input_port;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_i;
   logic        valid_i;
   logic        grant_i;
   logic        full_o;
   logic [15:0] q_o;
   logic        pop_req_o;
   logic [4:0]  route_o;
   logic [2:0]  count_o;
`ifdef NOC_INPUT_DROP_CNT_EN
   logic [7:0]  drop_cnt_o;
`endif

   logic [15:0] model_q[$];
   int          model_drops;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   noc_input_port #(
      .DEPTH    (DEPTH),
      .ROUTER_X (4'd1),
      .ROUTER_Y (4'd1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .full_o     (full_o),
      .q_o        (q_o),
      .pop_req_o  (pop_req_o),
      .route_o    (route_o),
      .grant_i    (grant_i),
      .count_o    (count_o)
`ifdef NOC_INPUT_DROP_CNT_EN
      ,
      .drop_cnt_o (drop_cnt_o)
`endif
   );

   // Expected one-hot {L,W,E,S,N} for a flit at router (1,1).
   function automatic logic [4:0] ref_route(input logic [15:0] f);
      int dx;
      int dy;
      dx = int'(f[15:12]);
      dy = int'(f[11:8]);
      if (dx > 1)      return 5'b00100;
      else if (dx < 1) return 5'b01000;
      else if (dy > 1) return 5'b00001;
      else if (dy < 1) return 5'b00010;
      else             return 5'b10000;
   endfunction

   task automatic check(input string tag, input logic [15:0] observed,
                        input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_all(input string ctx);
      logic [15:0] head;
      logic [4:0]  rt;
      int          n;
      n    = model_q.size();
      head = (n > 0) ? model_q[0] : 16'h0000;
      rt   = (n > 0) ? ref_route(head) : 5'b00000;
      check({ctx, ".q"},       q_o,                head);
      check({ctx, ".route"},   {11'd0, route_o},   {11'd0, rt});
      check({ctx, ".pop_req"}, {15'd0, pop_req_o}, {15'd0, n != 0});
      check({ctx, ".full"},    {15'd0, full_o},    {15'd0, n == DEPTH});
      check({ctx, ".count"},   {13'd0, count_o},   16'(n));
`ifdef NOC_INPUT_DROP_CNT_EN
      check({ctx, ".drops"},   {8'd0, drop_cnt_o}, 16'(model_drops));
`endif
   endtask

   // One clock: apply inputs, advance the model by the interface rules, compare.
   task automatic step(input string ctx, input logic v, input logic [15:0] d,
                       input logic g);
      bit was_full;
      valid_i  = v;
      data_i   = d;
      grant_i  = g;
      was_full = (model_q.size() == DEPTH);
      if (g && model_q.size() > 0)
         void'(model_q.pop_front());
      if (v && !was_full)
         model_q.push_back(d);
      if (v && was_full && model_drops < 255)
         model_drops++;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      grant_i = 1'b0;
      check_all(ctx);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      valid_i = 1'b0;
      grant_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_q.delete();
      model_drops = 0;
   endtask

   initial begin
      logic [15:0] route_flits[5];
      logic [4:0]  route_lit[5];
      route_flits = '{16'h21AB, 16'h01CD, 16'h12EF, 16'h1034, 16'h1155};
      route_lit   = '{5'b00100, 5'b01000, 5'b00001, 5'b00010, 5'b10000};
      data_i      = 16'h0000;
      model_drops = 0;

      // Reset then idle.
      do_reset();
      check_all("reset");
      step("idle", 1'b0, 16'h0000, 1'b0);
      step("idle_grant", 1'b0, 16'h0000, 1'b1);

      // Route decode for each direction, one flit at a time.
      for (int i = 0; i < 5; i++) begin
         step("route_push", 1'b1, route_flits[i], 1'b0);
         check("route_lit", {11'd0, route_o}, {11'd0, route_lit[i]});
         check("route_q", q_o, route_flits[i]);
         step("route_pop", 1'b0, 16'h0000, 1'b1);
      end

      // Overfill: fifth flit dropped, then drain in order.
      for (int i = 0; i < 5; i++)
         step("fill", 1'b1, 16'hA000 + 16'(i), 1'b0);
      check("fill_full", {15'd0, full_o}, 16'd1);
      for (int i = 0; i < 4; i++) begin
         check("drain_order", q_o, 16'hA000 + 16'(i));
         step("drain", 1'b0, 16'h0000, 1'b1);
      end
      check("drain_empty", {15'd0, pop_req_o}, 16'd0);

      // Full with simultaneous push and grant: push dropped, count 3.
      for (int i = 0; i < 4; i++)
         step("refill", 1'b1, 16'hB000 + 16'(i), 1'b0);
      step("full_pushpop", 1'b1, 16'hBEEF, 1'b1);
      check("full_pushpop_cnt", {13'd0, count_o}, 16'd3);
      check("full_pushpop_nfull", {15'd0, full_o}, 16'd0);
      while (model_q.size() > 0)
         step("drain2", 1'b0, 16'h0000, 1'b1);

      // Sustained push+grant across pointer wrap at several occupancies.
      for (int lvl = 1; lvl <= 3; lvl++) begin
         for (int i = 0; i < lvl; i++)
            step("sus_pre", 1'b1, 16'(($urandom)), 1'b0);
         for (int i = 0; i < 20; i++)
            step("sustain", 1'b1, 16'(($urandom)), 1'b1);
         check("sustain_cnt", {13'd0, count_o}, 16'(lvl));
         while (model_q.size() > 0)
            step("sus_drain", 1'b0, 16'h0000, 1'b1);
      end

      // Reset with three flits buffered; a push after reset comes out first.
      for (int i = 0; i < 3; i++)
         step("pre_rst", 1'b1, 16'hC000 + 16'(i), 1'b0);
      do_reset();
      check("midrst_cnt", {13'd0, count_o}, 16'd0);
      check("midrst_req", {15'd0, pop_req_o}, 16'd0);
      check_all("midrst");
      step("post_rst", 1'b1, 16'h2277, 1'b0);
      check("post_rst_q", q_o, 16'h2277);
      step("post_rst_pop", 1'b0, 16'h0000, 1'b1);

      // Random traffic, biased to visit both full and empty.
      for (int i = 0; i < 400; i++) begin
         logic v;
         logic g;
         v = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 75 : 35));
         g = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 75));
         step("random", v, 16'(($urandom)), g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_noc_input_port
